// File: rtl/g_rd_ctrl_pkg.sv
// Shared constants and types for the dense-polynomial g memory controllers.
// The reader (g_rd_ctrl) and the writer-side controller both import this
// package so that the word count, the last-word mask and the FSM encoding
// always match.
package g_rd_ctrl_pkg;

  localparam int G_ADDR_W  = 8;    // g RAM address width
  localparam int G_DAT_W   = 64;   // g RAM / output word width
  localparam int G_WORDS   = 159;  // words in g, addresses 0..G_WORDS-1
  localparam int LAST_BITS = 51;   // valid LSBs in word G_WORDS-1 (r = 10163)

  localparam logic [G_ADDR_W-1:0] LAST_ADDR = G_ADDR_W'(G_WORDS - 1);

  // Keeps the LAST_BITS valid bits of the final word and zeroes the pad bits.
  localparam logic [G_DAT_W-1:0] LAST_MASK =
    {{(G_DAT_W - LAST_BITS){1'b0}}, {LAST_BITS{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } g_state_e;

  // Clears the pad bits above r when the word is the final word of g.
  function automatic logic [G_DAT_W-1:0] mask_word(input logic [G_DAT_W-1:0] word,
                                                   input logic               is_last);
    return is_last ? (word & LAST_MASK) : word;
  endfunction

endpackage

// File: rtl/g_skid_buf.sv
// Two-entry FIFO sitting between the g RAM read port and the output FIFO.
// Push and pop may happen in the same cycle; a push into a full buffer or a
// pop from an empty one is ignored so the pointers can never wrap wrongly.
module g_skid_buf
  import g_rd_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [G_DAT_W-1:0] din_i,
  input  logic               pop_i,
  output logic [G_DAT_W-1:0] head_o,
  output logic [1:0]         count_o
);

  logic [G_DAT_W-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;

  logic pop_ok;
  logic push_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

  // Storage, pointers and occupancy; everything clears on reset.
  // NOTE: the two data entries are reset as well so that a run aborted by
  // reset cannot leave a stale word that later shows up on the head output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/g_rd_ctrl.sv
// Reader side of the dense-polynomial g memory. Reads g words 0..G_WORDS-1,
// masks the pad bits of the last word, streams the words into the output
// FIFO under full-flag backpressure, and accumulates the Hamming-weight
// parity of g so that odd weight can be confirmed at done.
module g_rd_ctrl
  import g_rd_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                weight_odd,
  output logic [G_ADDR_W-1:0] g_addr,
  output logic                g_re,
  input  logic [G_DAT_W-1:0]  g_din,
  output logic                fifo_out_wr,
  input  logic                fifo_out_full,
  output logic [G_DAT_W-1:0]  fifo_out_dout
);

  g_state_e            state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wo_q, wo_d;
  logic [G_ADDR_W-1:0] addr_q, addr_d;
  logic                infl_q, infl_d;            // a read was issued last cycle
  logic                infl_last_q, infl_last_d;  // ...and it was the last address

  logic [G_DAT_W-1:0]  buf_head;
  logic [1:0]          buf_count;
  logic                pop;
  logic                issue;
  logic [2:0]          occ_next;                  // occupancy after this cycle, before any new issue

  // The buffer head leaves whenever it exists and the FIFO can take it.
  assign pop = (buf_count != 2'd0) && !fifo_out_full;

  // Counting the in-flight read and this cycle's pop lets a read go out every
  // cycle at steady state while still never pushing a third word in.
  assign occ_next = 3'(buf_count) + 3'(infl_q) - 3'(pop);
  assign issue    = (state_q == ST_READ) && (occ_next < 3'd2);

  // Next-state logic for the FSM, read counter, in-flight tracking and parity.
  // NOTE: every _d signal gets its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wo_d        = wo_q;
    addr_d      = addr_q;
    infl_d      = issue;
    infl_last_d = issue && (addr_q == LAST_ADDR);

    if (pop) begin
      wo_d = wo_q ^ (^buf_head);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          busy_d  = 1'b1;
          addr_d  = '0;
          wo_d    = 1'b0;
        end
      end
      ST_READ: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + G_ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Buffer empty and nothing in flight once this cycle's pop lands.
        if (occ_next == 3'd0) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  // NOTE: state registers take non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wo_q        <= 1'b0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wo_q        <= wo_d;
      addr_q      <= addr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  // Read data lands one cycle after g_re; the last word is masked on entry.
  g_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (infl_q),
    .din_i   (mask_word(g_din, infl_last_q)),
    .pop_i   (pop),
    .head_o  (buf_head),
    .count_o (buf_count)
  );

  // g_re and fifo_out_wr follow fifo_out_full in the same cycle so the
  // stream can run without bubbles; everything else comes from registers.
  assign busy          = busy_q;
  assign done          = done_q;
  assign weight_odd    = wo_q;
  assign g_addr        = addr_q;
  assign g_re          = issue;
  assign fifo_out_wr   = pop;
  assign fifo_out_dout = pop ? buf_head : '0;

endmodule

// File: tb/tb_g_rd_ctrl.sv
// Bench for g_rd_ctrl: a synchronous g RAM model, a full-flag driver, and a
// per-cycle compare process checking the output stream against the masked
// RAM image and its XOR parity.
module tb_g_rd_ctrl;

  localparam int NW = 159;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, weight_odd;
  logic [7:0]  g_addr;
  logic        g_re;
  logic [63:0] g_din;
  logic        fifo_out_wr;
  logic        fifo_out_full;
  logic [63:0] fifo_out_dout;

  logic [63:0] ram [0:NW-1];

  int compared   = 0;
  int mismatched = 0;

  int cyc        = 0;
  int full_mode  = 0;  // 0: never full, 1: held full, 2: random
  int run_id     = 0;
  int seen_id    = 0;
  int wr_idx     = 0;
  int re_cnt     = 0;
  int done_cnt   = 0;
  int last_wr_cyc = 0;
  int second_gap = 0;
  logic gap_chk  = 1'b0;
  logic exp_par  = 1'b0;
  logic [63:0] first_dout = '0;
  logic [63:0] last_dout  = '0;

  g_rd_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .weight_odd    (weight_odd),
    .g_addr        (g_addr),
    .g_re          (g_re),
    .g_din         (g_din),
    .fifo_out_wr   (fifo_out_wr),
    .fifo_out_full (fifo_out_full),
    .fifo_out_dout (fifo_out_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read g RAM: data appears the cycle after g_re.
  always @(posedge clk) begin
    if (g_re) g_din <= ram[g_addr];
  end

  // Output FIFO full flag.
  always @(posedge clk) begin
    #1;
    case (full_mode)
      1:       fifo_out_full = 1'b1;
      2:       fifo_out_full = 1'($urandom_range(0, 1));
      default: fifo_out_full = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected output word i: the RAM word, with bits 63:51 of word 158 cleared.
  function automatic logic [63:0] model_word(input int i);
    logic [63:0] w;
    w = ram[i];
    if (i == NW - 1) w = w & 64'h0007_FFFF_FFFF_FFFF;
    return w;
  endfunction

  // Compare process: runs every cycle, away from the active edge.
  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id = run_id;
      wr_idx  = 0;
      re_cnt  = 0;
      exp_par = 1'b0;
      for (int i = 0; i < NW; i++) exp_par = exp_par ^ (^model_word(i));
    end
    if (rst) begin
      check("reset_ctrl", 64'({busy, done, weight_odd, g_re, fifo_out_wr, g_addr}), 64'd0);
      check("reset_dout", fifo_out_dout, 64'd0);
    end else begin
      if (g_re) begin
        re_cnt++;
        check("g_addr_range", 64'(g_addr < 8'(NW)), 64'd1);
      end
      if (fifo_out_wr) begin
        check("wr_while_full", 64'(fifo_out_full), 64'd0);
        check("busy_on_wr", 64'(busy), 64'd1);
        if (wr_idx < NW) begin
          check($sformatf("word_%0d", wr_idx), fifo_out_dout, model_word(wr_idx));
        end else begin
          check("extra_write", 64'(wr_idx), 64'(NW - 1));
        end
        if (gap_chk && wr_idx > 0) check("gap", 64'(cyc - last_wr_cyc), 64'd1);
        if (wr_idx == 0) first_dout = fifo_out_dout;
        if (wr_idx == 1) second_gap = cyc - last_wr_cyc;
        last_dout   = fifo_out_dout;
        last_wr_cyc = cyc;
        wr_idx++;
      end
      if (done) begin
        check("done_words", 64'(wr_idx), 64'(NW));
        check("done_parity", 64'(weight_odd), 64'(exp_par));
        check("done_busy", 64'(busy), 64'd0);
        check("done_latency", 64'(cyc - last_wr_cyc), 64'd1);
        done_cnt++;
      end
    end
  end

  task automatic start_run();
    @(posedge clk); #1;
    start = 1'b1;
    run_id++;
    @(negedge clk);
    check("busy_before", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after", 64'(busy), 64'd1);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done_cnt != d0), 64'd1);
    repeat (8) @(negedge clk);
    check("single_done", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (wr_idx < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reach_words", 64'(wr_idx >= n), 64'd1);
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: ramp pattern, never full, no gaps.
    for (int i = 0; i < NW; i++) ram[i] = {32'hA5A5_0000 + 32'(i), 32'h0};
    gap_chk = 1'b1;
    start_run();
    wait_done();
    gap_chk = 1'b0;
    check("t1_first", first_dout, 64'hA5A5_0000_0000_0000);
    check("t1_last", last_dout, 64'h0005_009E_0000_0000);
    check("t1_parity", 64'(weight_odd), 64'd0);

    // 2: only the last word set, pad bits must vanish.
    for (int i = 0; i < NW; i++) ram[i] = 64'h0;
    ram[NW-1] = 64'hFFFF_FFFF_FFFF_FFFF;
    start_run();
    wait_done();
    check("t2_last", last_dout, 64'h0007_FFFF_FFFF_FFFF);
    check("t2_parity", 64'(weight_odd), 64'd1);

    // 3: random contents, random backpressure.
    for (int i = 0; i < NW; i++) ram[i] = {$urandom, $urandom};
    @(negedge clk) full_mode = 2;
    start_run();
    wait_done();
    @(negedge clk) full_mode = 0;

    // 4: full held for 20 cycles after start.
    for (int i = 0; i < NW; i++) ram[i] = {$urandom, $urandom};
    @(negedge clk) full_mode = 1;
    start_run();
    repeat (19) @(negedge clk);
    check("t4_issues_stalled", 64'(re_cnt), 64'd2);
    check("t4_no_writes", 64'(wr_idx), 64'd0);
    full_mode = 0;
    wait_done();
    check("t4_back_to_back", 64'(second_gap), 64'd1);

    // 5: reset in the middle of the run, then a clean rerun.
    start_run();
    wait_words(80);
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_abort_done", 64'(done_cnt), 64'(d0));
    start_run();
    wait_done();

    // 6: a second start mid-run is ignored.
    start_run();
    wait_words(50);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
